// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris board renderer: colour index type,
// tetromino palette, border colour and the commit FSM state encoding.
package tetris_pkg;

    typedef logic [2:0] color_idx_t;

    // Index 0 is an empty cell; 1..7 are the I, O, T, S, Z, J, L tetromino colours.
    localparam logic [23:0] PALETTE [0:7] = '{
        24'h000000,
        24'h00FFFF,
        24'hFFFF00,
        24'hA000F0,
        24'h00FF00,
        24'hFF0000,
        24'h0000FF,
        24'hFFA500
    };

    localparam logic [23:0] BORDER_RGB = 24'hA0A0A0;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        COPY
    } render_state_e;

endpackage

// File: rtl/tetris_pixel_map.sv
// Combinational screen-to-board mapping: classifies a pixel as board, border or
// background and gives the cell it falls in plus whether it sits on the 1-px gap.
module tetris_pixel_map
    import tetris_pkg::*;
#(
    parameter int width_p     = 640,
    parameter int height_p    = 480,
    parameter int cols_p      = 10,
    parameter int rows_p      = 20,
    parameter int cell_px_p   = 16,
    parameter int origin_x_p  = 240,
    parameter int origin_y_p  = 80,
    parameter int border_px_p = 2
) (
    input  logic [$clog2(width_p)-1:0]  x_i,
    input  logic [$clog2(height_p)-1:0] y_i,
    output logic                        in_board_o,
    output logic                        in_border_o,
    output logic                        in_gap_o,
    output logic [$clog2(cols_p)-1:0]   cell_col_o,
    output logic [$clog2(rows_p)-1:0]   cell_row_o
);

    localparam int XW   = $clog2(width_p);
    localparam int YW   = $clog2(height_p);
    localparam int CW   = $clog2(cols_p);
    localparam int RW   = $clog2(rows_p);
    localparam int LOG2 = $clog2(cell_px_p);

    if (cell_px_p < 2 || (cell_px_p & (cell_px_p - 1)) != 0) begin : g_bad_cell_px
        $error("tetris_pixel_map: cell_px_p must be a power of two >= 2");
    end

    localparam logic signed [XW:0] X_END = (XW+1)'(cols_p * cell_px_p);
    localparam logic signed [YW:0] Y_END = (YW+1)'(rows_p * cell_px_p);
    localparam logic signed [XW:0] X_BLO = (XW+1)'(-border_px_p);
    localparam logic signed [YW:0] Y_BLO = (YW+1)'(-border_px_p);
    localparam logic signed [XW:0] X_BHI = (XW+1)'(cols_p * cell_px_p + border_px_p);
    localparam logic signed [YW:0] Y_BHI = (YW+1)'(rows_p * cell_px_p + border_px_p);

    // One extra bit so pixels left of / above the origin come out negative.
    logic signed [XW:0] dx;
    logic signed [YW:0] dy;

    assign dx = $signed({1'b0, x_i}) - $signed((XW+1)'(origin_x_p));
    assign dy = $signed({1'b0, y_i}) - $signed((YW+1)'(origin_y_p));

    assign in_board_o  = !dx[XW] && (dx < X_END) && !dy[YW] && (dy < Y_END);
    assign in_border_o = !in_board_o && (dx >= X_BLO) && (dx < X_BHI)
                                     && (dy >= Y_BLO) && (dy < Y_BHI);
    assign in_gap_o    = (dx[LOG2-1:0] == '1) || (dy[LOG2-1:0] == '1);
    assign cell_col_o  = CW'(dx[XW:LOG2]);
    assign cell_row_o  = RW'(dy[YW:LOG2]);

endmodule

// File: rtl/tetris_board_renderer.sv
// Zero-latency pixel source for the Tetris playfield: double-buffered colour
// index board, tear-free commit at end of frame, then front-to-back resync copy.
module tetris_board_renderer
    import tetris_pkg::*;
#(
    parameter int width_p     = 640,
    parameter int height_p    = 480,
    parameter int cols_p      = 10,
    parameter int rows_p      = 20,
    parameter int cell_px_p   = 16,
    parameter int origin_x_p  = 240,
    parameter int origin_y_p  = 80,
    parameter int border_px_p = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [$clog2(width_p)-1:0]  x_i,
    input  logic [$clog2(height_p)-1:0] y_i,
    input  logic                        xy_v_i,
    input  logic                        wr_v_i,
    output logic                        wr_ready_o,
    input  logic [$clog2(cols_p)-1:0]   wr_col_i,
    input  logic [$clog2(rows_p)-1:0]   wr_row_i,
    input  color_idx_t                  wr_color_i,
    input  logic                        swap_req_i,
    output logic                        swap_busy_o,
    output logic                        swap_done_o,
    output logic [7:0]                  r_o,
    output logic [7:0]                  g_o,
    output logic [7:0]                  b_o
);

    localparam int XW     = $clog2(width_p);
    localparam int YW     = $clog2(height_p);
    localparam int CW     = $clog2(cols_p);
    localparam int RW     = $clog2(rows_p);
    localparam int NCELLS = cols_p * rows_p;
    localparam int IW     = $clog2(NCELLS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCELLS - 1);

    render_state_e   state_q, state_d;
    logic            front_sel_q;
    logic [IW-1:0]   copy_idx_q;
    logic            swap_done_q;
    color_idx_t      buf_q [2][NCELLS];

    logic            wr_fire, wr_in_range, frame_end, do_toggle;
    logic [IW-1:0]   wr_idx, pix_idx;
    logic            in_board, in_border, in_gap;
    logic [CW-1:0]   cell_col;
    logic [RW-1:0]   cell_row;
    logic [23:0]     rgb;

    assign wr_fire     = wr_v_i && wr_ready_o;
    assign wr_in_range = (int'(wr_col_i) < cols_p) && (int'(wr_row_i) < rows_p);
    assign wr_idx      = IW'(wr_row_i) * IW'(cols_p) + IW'(wr_col_i);
    assign frame_end   = xy_v_i && (x_i == XW'(width_p - 1)) && (y_i == YW'(height_p - 1));
    assign swap_busy_o = (state_q != IDLE);
    assign swap_done_o = swap_done_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_ready_o = 1'b0;
        do_toggle  = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_ready_o = 1'b1;
                if (swap_req_i) state_d = PEND;
            end
            PEND: begin
                if (frame_end) begin
                    do_toggle = 1'b1;
                    state_d   = COPY;
                end
            end
            COPY: begin
                if (copy_idx_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            copy_idx_q  <= '0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            swap_done_q <= (state_q == COPY) && (copy_idx_q == LAST_IDX);
            if (do_toggle) begin
                front_sel_q <= ~front_sel_q;
                copy_idx_q  <= '0;
            end else if (state_q == COPY) begin
                copy_idx_q  <= copy_idx_q + IW'(1);
            end
        end
    end

    // NOTE: the board is a flop array, not RAM, so it can and must be cleared by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NCELLS; i++) begin
                    buf_q[b][i] <= '0;
                end
            end
        end else if (state_q == COPY) begin
            buf_q[~front_sel_q][copy_idx_q] <= buf_q[front_sel_q][copy_idx_q];
        end else if (wr_fire && wr_in_range) begin
            buf_q[~front_sel_q][wr_idx] <= wr_color_i;
        end
    end

    tetris_pixel_map #(
        .width_p     (width_p),
        .height_p    (height_p),
        .cols_p      (cols_p),
        .rows_p      (rows_p),
        .cell_px_p   (cell_px_p),
        .origin_x_p  (origin_x_p),
        .origin_y_p  (origin_y_p),
        .border_px_p (border_px_p)
    ) u_pixel_map (
        .x_i         (x_i),
        .y_i         (y_i),
        .in_board_o  (in_board),
        .in_border_o (in_border),
        .in_gap_o    (in_gap),
        .cell_col_o  (cell_col),
        .cell_row_o  (cell_row)
    );

    // Gated so the lookup index stays in range outside the board.
    assign pix_idx = in_board ? (IW'(cell_row) * IW'(cols_p) + IW'(cell_col)) : '0;

    always_comb begin
        rgb = 24'h000000;
        if (xy_v_i) begin
            if (in_board) begin
                if (!in_gap) rgb = PALETTE[buf_q[front_sel_q][pix_idx]];
            end else if (in_border) begin
                rgb = BORDER_RGB;
            end
        end
    end

    assign r_o = rgb[23:16];
    assign g_o = rgb[15:8];
    assign b_o = rgb[7:0];

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Self-checking bench for tetris_board_renderer: randomized writes/commits scored
// against a board-level model and a pixel-rule reference computed with plain ints.
`timescale 1ns/100ps
module tb_tetris_board_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [8:0] y;
    logic       xy_v;
    logic       wr_v;
    logic       wr_ready;
    logic [3:0] wr_col;
    logic [4:0] wr_row;
    logic [2:0] wr_color;
    logic       swap_req;
    logic       swap_busy;
    logic       swap_done;
    logic [7:0] r, g, b;

    int errors = 0;
    int checks = 0;

    // Reference model: what is on screen and what game logic has staged.
    int disp [20][10];
    int pend [20][10];

    logic [23:0] pal [8];

    tetris_board_renderer dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .x_i         (x),
        .y_i         (y),
        .xy_v_i      (xy_v),
        .wr_v_i      (wr_v),
        .wr_ready_o  (wr_ready),
        .wr_col_i    (wr_col),
        .wr_row_i    (wr_row),
        .wr_color_i  (wr_color),
        .swap_req_i  (swap_req),
        .swap_busy_o (swap_busy),
        .swap_done_o (swap_done),
        .r_o         (r),
        .g_o         (g),
        .b_o         (b)
    );

    always #20 clk = ~clk;

    function automatic logic [23:0] exp_pix(input int px, input int py, input bit v);
        int bx, by;
        if (!v) return 24'h0;
        bx = px - 240;
        by = py - 80;
        if (bx >= 0 && bx < 160 && by >= 0 && by < 320) begin
            if (bx % 16 == 15 || by % 16 == 15) return 24'h0;
            return pal[disp[by / 16][bx / 16]];
        end
        if (bx >= -2 && bx < 162 && by >= -2 && by < 322) return 24'hA0A0A0;
        return 24'h0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int px, input int py, input bit v, output logic [23:0] rgb);
        x    = 10'(px);
        y    = 9'(py);
        xy_v = v;
        #1;
        rgb  = {r, g, b};
    endtask

    task automatic clear_model;
        for (int rr = 0; rr < 20; rr++)
            for (int cc = 0; cc < 10; cc++) begin
                disp[rr][cc] = 0;
                pend[rr][cc] = 0;
            end
    endtask

    task automatic write_cell(input int col, input int row, input int color, input string name);
        wr_v     = 1'b1;
        wr_col   = 4'(col);
        wr_row   = 5'(row);
        wr_color = 3'(color);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: wr_ready got %b expected 1", name, wr_ready);
        end
        tick();
        wr_v = 1'b0;
        if (col < 10 && row < 20) pend[row][col] = color;
    endtask

    task automatic request_swap;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    // Presents the last active pixel for one cycle; the DUT toggles on that edge.
    task automatic end_frame;
        x    = 10'd639;
        y    = 9'd479;
        xy_v = 1'b1;
        tick();
        xy_v = 1'b0;
        disp = pend;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (swap_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != 200) begin
            errors++;
            $display("FAIL %s: swap_done after %0d cycles expected 200", name, n);
        end
        checks++;
        if (swap_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: swap_busy at done got %b expected 0", name, swap_busy);
        end
    endtask

    task automatic commit(input string name);
        int n;
        request_swap();
        end_frame();
        wait_done(name, n);
    endtask

    task automatic check_board(input string name);
        logic [23:0] got, exp;
        int bad = 0;
        logic [23:0] first_got = '0, first_exp = '0;
        for (int rr = 0; rr < 20; rr++)
            for (int cc = 0; cc < 10; cc++) begin
                probe(240 + cc * 16 + 7, 80 + rr * 16 + 7, 1'b1, got);
                exp = pal[disp[rr][cc]];
                if (got !== exp) begin
                    if (bad == 0) begin
                        first_got = got;
                        first_exp = exp;
                    end
                    bad++;
                end
            end
        xy_v = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cells, first got %06h expected %06h", name, bad, first_got, first_exp);
        end
        tick();
    endtask

    task automatic check_random_pixels(input string name, input int n);
        logic [23:0] got, exp;
        int px, py, bad = 0;
        bit v;
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) begin
                px = $urandom_range(230, 410);
                py = $urandom_range(70, 410);
            end else begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 479);
            end
            v = ($urandom_range(0, 7) != 0);
            probe(px, py, v, got);
            exp = exp_pix(px, py, v);
            if (got !== exp) begin
                if (bad == 0) $display("FAIL %s: pixel (%0d,%0d) v=%0b got %06h expected %06h", name, px, py, v, got, exp);
                bad++;
            end
        end
        xy_v = 1'b0;
        checks++;
        if (bad != 0) errors++;
        tick();
    endtask

    task automatic check_pixel(input string name, input int px, input int py, input logic [23:0] exp);
        logic [23:0] got;
        probe(px, py, 1'b1, got);
        xy_v = 1'b0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        logic [23:0] got, exp;
        int bad = 0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        clear_model();
        checks++;
        if ({wr_ready, swap_busy, swap_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_outputs: ready/busy/done got %b expected 100", {wr_ready, swap_busy, swap_done});
        end
        for (int py = 0; py < 480; py++)
            for (int px = 0; px < 640; px++) begin
                probe(px, py, 1'b1, got);
                exp = exp_pix(px, py, 1'b1);
                if (got !== exp) begin
                    if (bad == 0) $display("FAIL reset_frame: pixel (%0d,%0d) got %06h expected %06h", px, py, got, exp);
                    bad++;
                end
            end
        xy_v = 1'b0;
        checks++;
        if (bad != 0) errors++;
        tick();
    endtask

    task automatic test_swap_basic;
        int n;
        write_cell(0, 0, 3, "basic_write");
        check_pixel("basic_front_unchanged", 240, 80, 24'h0);
        request_swap();
        checks++;
        if (swap_busy !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_pend_flags: busy/ready got %b%b expected 10", swap_busy, wr_ready);
        end
        check_pixel("basic_pend_old_front", 240, 80, 24'h0);
        end_frame();
        wait_done("basic_done", n);
        check_pixel("basic_cell_colour", 240, 80, pal[3]);
        check_pixel("basic_cell_inner", 254, 94, pal[3]);
        check_pixel("basic_gap_col", 255, 80, 24'h0);
        check_pixel("basic_gap_row", 240, 95, 24'h0);
        tick();
        checks++;
        if (swap_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: swap_done got %b expected 0", swap_done);
        end
    endtask

    task automatic test_write_while_busy;
        int n;
        request_swap();
        wr_v = 1'b1; wr_col = 4'd5; wr_row = 5'd5; wr_color = 3'd6;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_pend_ready: got %b expected 0", wr_ready);
            end
            tick();
        end
        wr_v = 1'b0;
        end_frame();
        wr_v = 1'b1; wr_col = 4'd2; wr_row = 5'd1; wr_color = 3'd7;
        n = 0;
        while (wr_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != 200 || swap_done !== 1'b1) begin
            errors++;
            $display("FAIL busy_first_idle: ready after %0d cycles done=%b expected 200 and 1", n, swap_done);
        end
        tick();
        wr_v = 1'b0;
        pend[1][2] = 7;
        commit("busy_commit");
        check_board("busy_board");
    endtask

    task automatic test_out_of_range;
        write_cell(12, 3, 5, "oor_col_ready");
        write_cell(4, 25, 2, "oor_row_ready");
        commit("oor_commit");
        check_board("oor_board");
    endtask

    task automatic test_swap_and_write_same_cycle;
        int n;
        wr_v = 1'b1; wr_col = 4'd4; wr_row = 5'd7; wr_color = 3'd2;
        swap_req = 1'b1;
        tick();
        wr_v = 1'b0;
        swap_req = 1'b0;
        pend[7][4] = 2;
        repeat (2) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        end_frame();
        wait_done("same_cycle_done", n);
        repeat (3) tick();
        checks++;
        if (swap_busy !== 1'b0) begin
            errors++;
            $display("FAIL double_req_ignored: swap_busy got %b expected 0", swap_busy);
        end
        check_board("same_cycle_board");
    endtask

    task automatic test_reset_mid_copy;
        for (int k = 0; k < 30; k++)
            write_cell($urandom_range(0, 9), $urandom_range(0, 19), $urandom_range(1, 7), "midcopy_fill");
        request_swap();
        end_frame();
        repeat (57) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        checks++;
        if ({wr_ready, swap_busy, swap_done} !== 3'b100) begin
            errors++;
            $display("FAIL midcopy_reset_flags: ready/busy/done got %b expected 100", {wr_ready, swap_busy, swap_done});
        end
        check_board("midcopy_front_zero");
        commit("midcopy_commit");
        check_board("midcopy_back_zero");
    endtask

    task automatic test_random;
        for (int round = 0; round < 4; round++) begin
            int nw = $urandom_range(10, 40);
            for (int k = 0; k < nw; k++)
                write_cell($urandom_range(0, 11), $urandom_range(0, 21), $urandom_range(0, 7), "rand_write");
            commit("rand_commit");
            check_board("rand_board");
            check_random_pixels("rand_pixels", 400);
        end
    endtask

    initial begin
        pal = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'hA000F0,
                24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFA500};
        reset = 1'b1; x = '0; y = '0; xy_v = 1'b0;
        wr_v = 1'b0; wr_col = '0; wr_row = '0; wr_color = '0; swap_req = 1'b0;
        clear_model();
        test_reset();
        test_swap_basic();
        test_write_while_busy();
        test_out_of_range();
        test_swap_and_write_same_cycle();
        test_reset_mid_copy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
